uart_tx_feeder: RTL

//   Byte buffer and handshake sequencer directly upstream of the UART transmitter.

---
 rtl/uart_tx_feeder_pkg.sv | 12 +
 rtl/uart_tx_feeder_sync_fifo.sv | 76 +++++++
 rtl/uart_tx_feeder.sv | 106 ++++++++++
 3 files changed

// File: rtl/uart_tx_feeder_pkg.sv
// Shared constants for the UART transmit feeder: handshake FSM encoding and byte width.
package uart_tx_feeder_pkg;

  localparam int UART_BYTE_W = 8;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_BUSY = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;

  typedef logic [UART_BYTE_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// Single-clock FIFO with registered full/empty/level; shared by the TX feeder and RX-side buffering.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset_p,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_pop_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             r_full;
  logic             r_empty;
  logic [AW:0]      w_level_next;
  logic             w_push_ok;
  logic             w_pop_ok;

  // A push while full is refused even if a pop frees a slot on the same edge.
  assign w_push_ok = i_push && !r_full;
  assign w_pop_ok  = i_pop && !r_empty;

  always_comb begin
    w_level_next = r_level;
    if (w_push_ok && !w_pop_ok) begin
      w_level_next = r_level + LVL_ONE;
    end else if (!w_push_ok && w_pop_ok) begin
      w_level_next = r_level - LVL_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset_p) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_level <= w_level_next;
      r_full  <= (w_level_next == LVL_FULL);
      r_empty <= (w_level_next == '0);
    end
  end

  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_full     = r_full;
  assign o_empty    = r_empty;
  assign o_level    = r_level;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and hands them to the UART transmitter one at a time using a
// valid pulse / busy-rise / busy-fall handshake, retrying the pulse if busy never rises.
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset_p,
  input  logic                     i_wr_en,
  input  logic [UART_BYTE_W-1:0]   i_wr_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overflow,
  output logic [UART_BYTE_W-1:0]   o_tx_data,
  output logic                     o_tx_valid,
  input  logic                     i_tx_busy
);

  // state       | meaning
  // S_IDLE      | waiting for a queued byte and an idle transmitter
  // S_WAIT_BUSY | byte offered, waiting for busy to rise (retry on timeout)
  // S_WAIT_DONE | transmitter accepted, waiting for busy to fall

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  logic [1:0]             r_state;
  logic [TW-1:0]          r_timer;
  uart_byte_t             r_tx_data;
  logic                   r_tx_valid;
  logic                   r_overflow;
  uart_byte_t             w_head;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic                   w_issue;

  assign w_issue = (r_state == S_IDLE) && !w_fifo_empty && !i_tx_busy;

  sync_fifo #(
    .WIDTH (UART_BYTE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset_p   (i_reset_p),
    .i_push      (i_wr_en),
    .i_push_data (i_wr_data),
    .i_pop       (w_issue),
    .o_pop_data  (w_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_level     (o_level)
  );

  // Timer counts down from ACK_TIMEOUT-1; reaching zero without busy re-offers the byte.
  always_ff @(posedge i_clk) begin
    if (i_reset_p) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_tx_valid <= 1'b0;
      if (i_wr_en && w_fifo_full) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_tx_data  <= w_head;
            r_tx_valid <= 1'b1;
            r_timer    <= TIMER_LOAD;
            r_state    <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          if (i_tx_busy) begin
            r_state <= S_WAIT_DONE;
          end else if (r_timer == '0) begin
            r_tx_valid <= 1'b1;
            r_timer    <= TIMER_LOAD;
          end else begin
            r_timer <= r_timer - TIMER_ONE;
          end
        end
        S_WAIT_DONE: begin
          if (!i_tx_busy) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_full     = w_fifo_full;
  assign o_empty    = w_fifo_empty;
  assign o_overflow = r_overflow;
  assign o_tx_data  = r_tx_data;
  assign o_tx_valid = r_tx_valid;

endmodule
